// File: rtl/pe_row_feeder.sv
// West-edge feeder for the weight-stationary PE array: buffers a weight tile, bursts it into the
// rows, then streams activation vectors through a per-row diagonal skew line.
module pe_row_feeder #(
    parameter int unsigned ARRAY_DIM          = 4,
    parameter int unsigned COMPUTE_DATA_WIDTH = 4,
    parameter int unsigned CNT_W              = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start_i,
    input  logic [CNT_W-1:0]                           num_vecs_i,
    input  logic                                       in_valid_i,
    output logic                                       in_ready_o,
    input  logic [ARRAY_DIM*COMPUTE_DATA_WIDTH-1:0]    in_data_i,
    output logic [ARRAY_DIM*COMPUTE_DATA_WIDTH-1:0]    row_data_o,
    output logic [ARRAY_DIM-1:0]                       row_valid_o,
    output logic                                       load_en_o,
    output logic                                       compute_o,
    output logic                                       busy_o,
    output logic                                       done_o
);

    localparam int unsigned Cdw    = COMPUTE_DATA_WIDTH;
    localparam int unsigned VecW   = ARRAY_DIM * Cdw;
    localparam int unsigned IdxW   = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
    localparam int unsigned DrnW   = $clog2(2 * ARRAY_DIM);
    localparam int unsigned NumStg = ARRAY_DIM * (ARRAY_DIM - 1) / 2;
    localparam int unsigned StgN   = (NumStg > 0) ? NumStg : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(ARRAY_DIM - 1);
    localparam logic [DrnW-1:0] DrnLast = DrnW'(2 * ARRAY_DIM - 2);

    typedef enum logic [2:0] {StIdle, StWFill, StWShift, StCompute, StDrain} state_e;

    state_e                        state_q, state_d;
    logic [IdxW-1:0]               wcnt_q, wcnt_d, kcnt_q, kcnt_d;
    logic [CNT_W-1:0]              nvec_q, nvec_d, vcnt_q, vcnt_d;
    logic [DrnW-1:0]               dcnt_q, dcnt_d;
    logic [ARRAY_DIM-1:0][VecW-1:0] wbuf_q, wbuf_d;
    // Internal skew stages, packed as a triangle: row r owns r entries starting at r*(r-1)/2.
    logic [StgN-1:0][Cdw-1:0]      stg_data_q, stg_data_d;
    logic [StgN-1:0]               stg_vld_q, stg_vld_d;
    logic [VecW-1:0]               row_data_q, row_data_d;
    logic [ARRAY_DIM-1:0]          row_valid_q, row_valid_d;
    logic                          load_en_q, load_en_d, compute_q, compute_d;
    logic                          busy_q, busy_d, done_q, done_d;
    logic                          xfer, skew_run;

    assign in_ready_o = (state_q == StWFill) || (state_q == StCompute);
    assign xfer       = in_valid_i & in_ready_o;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        kcnt_d  = kcnt_q;
        nvec_d  = nvec_q;
        vcnt_d  = vcnt_q;
        dcnt_d  = dcnt_q;
        wbuf_d  = wbuf_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StWFill;
                    nvec_d  = num_vecs_i;
                    wcnt_d  = '0;
                end
            end
            StWFill: begin
                if (xfer) begin
                    wbuf_d[wcnt_q] = in_data_i;
                    wcnt_d         = wcnt_q + IdxW'(1);
                    if (wcnt_q == IdxLast) begin
                        state_d = StWShift;
                        wcnt_d  = '0;
                        kcnt_d  = '0;
                    end
                end
            end
            StWShift: begin
                if (kcnt_q == IdxLast) begin
                    state_d = (nvec_q != '0) ? StCompute : StDrain;
                    vcnt_d  = '0;
                    dcnt_d  = '0;
                end else begin
                    kcnt_d = kcnt_q + IdxW'(1);
                end
            end
            StCompute: begin
                if (xfer) begin
                    vcnt_d = vcnt_q + CNT_W'(1);
                    // Compare before increment so a full-scale count never wraps.
                    if (vcnt_q == nvec_q - CNT_W'(1)) begin
                        state_d = StDrain;
                        dcnt_d  = '0;
                    end
                end
            end
            StDrain: begin
                if (dcnt_q == DrnLast) begin
                    state_d = StIdle;
                end else begin
                    dcnt_d = dcnt_q + DrnW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign skew_run = ((state_q == StCompute) || (state_q == StDrain)) && (state_d != StIdle);

    always_comb begin
        stg_data_d  = '0;
        stg_vld_d   = '0;
        row_data_d  = '0;
        row_valid_d = '0;
        if (state_d == StWShift) begin
            row_data_d = wbuf_d[kcnt_d];
        end else if (skew_run) begin
            for (int unsigned r = 0; r < ARRAY_DIM; r++) begin
                if (r == 0) begin
                    row_data_d[0 +: Cdw] = xfer ? in_data_i[0 +: Cdw] : '0;
                    row_valid_d[0]       = xfer;
                end else begin
                    stg_data_d[r*(r-1)/2] = xfer ? in_data_i[r*Cdw +: Cdw] : '0;
                    stg_vld_d[r*(r-1)/2]  = xfer;
                    for (int unsigned j = 1; j < r; j++) begin
                        stg_data_d[r*(r-1)/2 + j] = stg_data_q[r*(r-1)/2 + j - 1];
                        stg_vld_d[r*(r-1)/2 + j]  = stg_vld_q[r*(r-1)/2 + j - 1];
                    end
                    row_data_d[r*Cdw +: Cdw] = stg_data_q[r*(r-1)/2 + r - 1];
                    row_valid_d[r]           = stg_vld_q[r*(r-1)/2 + r - 1];
                end
            end
        end
        load_en_d = (state_d == StWShift);
        compute_d = (state_d == StCompute) || (state_d == StDrain);
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDrain) && (dcnt_d == DrnLast);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wcnt_q      <= '0;
            kcnt_q      <= '0;
            nvec_q      <= '0;
            vcnt_q      <= '0;
            dcnt_q      <= '0;
            wbuf_q      <= '0;
            stg_data_q  <= '0;
            stg_vld_q   <= '0;
            row_data_q  <= '0;
            row_valid_q <= '0;
            load_en_q   <= 1'b0;
            compute_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            kcnt_q      <= kcnt_d;
            nvec_q      <= nvec_d;
            vcnt_q      <= vcnt_d;
            dcnt_q      <= dcnt_d;
            wbuf_q      <= wbuf_d;
            stg_data_q  <= stg_data_d;
            stg_vld_q   <= stg_vld_d;
            row_data_q  <= row_data_d;
            row_valid_q <= row_valid_d;
            load_en_q   <= load_en_d;
            compute_q   <= compute_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign row_data_o  = row_data_q;
    assign row_valid_o = row_valid_q;
    assign load_en_o   = load_en_q;
    assign compute_o   = compute_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
